// File: rtl/kbus_plotter.sv
// K-bus pixel-plot receiver: queues {X,Y,colour} commands, clips them,
// and writes visible pixels into the framebuffer via req/ack.
module kbus_plotter #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              k_valid,
  input  logic [23:0]       k_data,
  output logic              k_ready,
  output logic              fb_req,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  input  logic              fb_ack,
  output logic              busy,
  output logic [15:0]       plot_count,
  output logic [7:0]        clip_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [31:0] XM = X_MAX;
  localparam logic [31:0] YM = Y_MAX;
  localparam logic [31:0] W  = X_MAX + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_nx;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        push;
  logic        pop;
  logic        clip;
  logic        done;
  logic [23:0] head;
  logic [31:0] hx;
  logic [31:0] hy;
  logic [31:0] addr_full;

  assign k_ready = (count != FULL);
  assign busy    = (count != '0) || (state == REQ);

  assign push = k_valid && k_ready;
  assign pop  = (state == IDLE) && (count != '0);
  assign done = (state == REQ) && fb_ack;

  assign head = mem[rd_ptr];
  assign hx   = {24'd0, head[23:16]};
  assign hy   = {24'd0, head[15:8]};
  assign clip = (hx > XM) || (hy > YM);

  // Full-width linear address; only the low ADDR_W bits reach the RAM.
  assign addr_full = hy * W + hx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= k_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (pop && !clip) state_nx = REQ;
      REQ:  if (fb_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_req  <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (pop && !clip) begin
      fb_req  <= 1'b1;
      fb_addr <= addr_full[ADDR_W-1:0];
      fb_data <= head[7:0];
    end else if (done) begin
      fb_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count <= '0;
      clip_count <= '0;
    end else begin
      if (done) begin
        plot_count <= plot_count + 1'b1;
      end
      if (pop && clip && clip_count != 8'hFF) begin
        clip_count <= clip_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kbus_plotter.sv
// Directed bench for kbus_plotter: plotting, backpressure, clipping,
// ack hold, simultaneous push/pop and asynchronous reset mid-write.
module tb_kbus_plotter;

  logic        clk;
  logic        rst_n;
  logic        k_valid;
  logic [23:0] k_data;
  logic        k_ready;
  logic        fb_req;
  logic [14:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ack;
  logic        busy;
  logic [15:0] plot_count;
  logic [7:0]  clip_count;

  int checks   = 0;
  int failures = 0;
  int exp_plot = 0;
  int req_seen = 0;

  logic [22:0] mon_q [$];

  kbus_plotter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .k_valid    (k_valid),
    .k_data     (k_data),
    .k_ready    (k_ready),
    .fb_req     (fb_req),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ack     (fb_ack),
    .busy       (busy),
    .plot_count (plot_count),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fb_req) req_seen++;
    if (fb_req && fb_ack) mon_q.push_back({fb_addr, fb_data});
  end

  function automatic logic [22:0] exp_wr(input logic [23:0] c);
    logic [14:0] a;
    a = 15'(int'(c[15:8]) * 160 + int'(c[23:16]));
    return {a, c[7:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [23:0] d);
    int t;
    t = 0;
    k_valid = 1'b1;
    k_data  = d;
    while (!k_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!k_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got k_ready=%0b exp=1", k_ready);
    end
    @(negedge clk);
    k_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got busy=%0b exp=0", busy);
    end
    @(negedge clk);
  endtask

  task automatic check_order(input logic [23:0] c [6], input int n);
    checks++;
    if (mon_q.size() !== n) begin
      failures++;
      $display("FAIL write_count got=%0d exp=%0d", mon_q.size(), n);
    end
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_wr(c[i])) begin
        failures++;
        $display("FAIL write_%0d got=%h exp=%h", i, mon_q[i], exp_wr(c[i]));
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    k_valid = 1'b0;
    k_data  = '0;
    fb_ack  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({k_ready, fb_req, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=100", {k_ready, fb_req, busy});
    end
    checks++;
    if ({fb_addr, fb_data, plot_count, clip_count} !== '0) begin
      failures++;
      $display("FAIL reset_values got=%h/%h/%h/%h exp=0",
               fb_addr, fb_data, plot_count, clip_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_plot();
    fb_ack = 1'b1;
    mon_q.delete();
    push_cmd(24'h0A053C);
    checks++;
    if ({fb_req, busy} !== 2'b01) begin
      failures++;
      $display("FAIL single_queued got=%b exp=01", {fb_req, busy});
    end
    @(negedge clk);
    checks++;
    if ({fb_req, fb_addr, fb_data} !== {1'b1, 15'd810, 8'h3C}) begin
      failures++;
      $display("FAIL single_req got=%b/%0d/%h exp=1/810/3c",
               fb_req, fb_addr, fb_data);
    end
    @(negedge clk);
    exp_plot++;
    checks++;
    if ({fb_req, busy} !== 2'b00 || plot_count !== 16'(exp_plot)) begin
      failures++;
      $display("FAIL single_done got=%b/%0d exp=00/%0d",
               {fb_req, busy}, plot_count, exp_plot);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] c [6];
    for (int i = 0; i < 6; i++) begin
      c[i] = {8'(i * 25 + 3), 8'(i * 19 + 1), 8'(8'h40 + i)};
    end
    fb_ack = 1'b0;
    mon_q.delete();
    for (int i = 0; i < 5; i++) push_cmd(c[i]);
    checks++;
    if ({k_ready, fb_req, busy} !== 3'b011) begin
      failures++;
      $display("FAIL full_flags got=%b exp=011", {k_ready, fb_req, busy});
    end
    fb_ack = 1'b1;
    push_cmd(c[5]);
    wait_idle();
    exp_plot += 6;
    checks++;
    if (plot_count !== 16'(exp_plot)) begin
      failures++;
      $display("FAIL bp_plot_count got=%0d exp=%0d", plot_count, exp_plot);
    end
    check_order(c, 6);
  endtask

  task automatic test_clipping();
    fb_ack = 1'b1;
    mon_q.delete();
    push_cmd({8'd160, 8'd0, 8'h11});
    push_cmd({8'd0, 8'd120, 8'h22});
    push_cmd({8'd159, 8'd119, 8'h77});
    wait_idle();
    exp_plot++;
    checks++;
    if (clip_count !== 8'd2 || plot_count !== 16'(exp_plot)) begin
      failures++;
      $display("FAIL clip_counts got=%0d/%0d exp=2/%0d",
               clip_count, plot_count, exp_plot);
    end
    checks++;
    if (mon_q.size() !== 1 || mon_q[0] !== {15'd19199, 8'h77}) begin
      failures++;
      $display("FAIL clip_corner got=%0d writes exp=1 at 19199/77",
               mon_q.size());
    end
    for (int i = 0; i < 300; i++) push_cmd({8'd200, 8'd7, 8'h01});
    wait_idle();
    checks++;
    if (clip_count !== 8'd255) begin
      failures++;
      $display("FAIL clip_saturate got=%0d exp=255", clip_count);
    end
  endtask

  task automatic test_ack_hold();
    fb_ack = 1'b0;
    push_cmd({8'd3, 8'd2, 8'hA5});
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({fb_req, fb_addr, fb_data} !== {1'b1, 15'd323, 8'hA5}) begin
        failures++;
        $display("FAIL hold_%0d got=%b/%0d/%h exp=1/323/a5",
                 i, fb_req, fb_addr, fb_data);
      end
      @(negedge clk);
    end
    fb_ack = 1'b1;
    @(negedge clk);
    fb_ack = 1'b0;
    exp_plot++;
    checks++;
    if (fb_req !== 1'b0 || plot_count !== 16'(exp_plot)) begin
      failures++;
      $display("FAIL hold_ack got=%b/%0d exp=0/%0d",
               fb_req, plot_count, exp_plot);
    end
    @(negedge clk);
    fb_ack = 1'b1;
    @(negedge clk);
    fb_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (fb_req !== 1'b0 || plot_count !== 16'(exp_plot)) begin
      failures++;
      $display("FAIL stray_ack got=%b/%0d exp=0/%0d",
               fb_req, plot_count, exp_plot);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] c [6];
    for (int i = 0; i < 6; i++) begin
      c[i] = {8'(150 - i * 13), 8'(i * 21), 8'(8'hC0 + i)};
    end
    fb_ack = 1'b0;
    mon_q.delete();
    push_cmd(c[0]);
    push_cmd(c[1]);
    push_cmd(c[2]);
    fb_ack = 1'b1;
    @(negedge clk);
    fb_ack = 1'b0;
    push_cmd(c[3]);
    checks++;
    if (k_ready !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_ready got=%b exp=1", k_ready);
    end
    push_cmd(c[4]);
    checks++;
    if (k_ready !== 1'b1) begin
      failures++;
      $display("FAIL three_ready got=%b exp=1", k_ready);
    end
    push_cmd(c[5]);
    checks++;
    if (k_ready !== 1'b0) begin
      failures++;
      $display("FAIL four_ready got=%b exp=0", k_ready);
    end
    fb_ack = 1'b1;
    wait_idle();
    exp_plot += 6;
    checks++;
    if (plot_count !== 16'(exp_plot)) begin
      failures++;
      $display("FAIL b2b_plot_count got=%0d exp=%0d", plot_count, exp_plot);
    end
    check_order(c, 6);
  endtask

  task automatic test_reset_mid_write();
    int base;
    fb_ack = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd({8'(i + 1), 8'(i), 8'h5A});
    checks++;
    if ({fb_req, k_ready, busy} !== 3'b111) begin
      failures++;
      $display("FAIL pre_reset got=%b exp=111", {fb_req, k_ready, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fb_req, busy, k_ready} !== 3'b001 ||
        plot_count !== 16'd0 || clip_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d/%0d exp=001/0/0",
               {fb_req, busy, k_ready}, plot_count, clip_count);
    end
    base = req_seen;
    #1 rst_n = 1'b1;
    fb_ack = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (req_seen !== base || busy !== 1'b0 || plot_count !== 16'd0) begin
      failures++;
      $display("FAIL post_reset got=%0d reqs busy=%b plots=%0d exp=0/0/0",
               req_seen - base, busy, plot_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_plot();
    test_backpressure();
    test_clipping();
    test_ack_hold();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
